// File: rtl/display_pkg.sv
// Shared constants for the front-panel display path: digit geometry, segment
// bit positions, FSM encoding and the hex font.
package display_pkg;

  localparam int NUM_DIGITS = 9;
  localparam int SEG_W      = 8;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  // Entry 15 is listed first so that HEX_FONT[n] is the glyph for nibble n
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [SEG_W-1:0] seg_byte(input logic [6:0] segs,
                                                input logic dp,
                                                input logic blank);
    logic [SEG_W-1:0] b;
    b = '0;
    if (!blank) begin
      b[SEG_G:SEG_A] = segs;
      b[SEG_DP]      = dp;
    end
    return b;
  endfunction

endpackage

// File: rtl/seg7_font.sv
// Combinational hex-nibble to seven-segment lookup, shared by every digit.
module seg7_font
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  assign segs = HEX_FONT[nibble];

endmodule

// File: rtl/display_formatter.sv
// Builds the 72-bit display image serially into a shadow buffer, commits it
// atomically, and gates blinking digits with a free-running phase.
module display_formatter #(
  parameter int NUM_DIGITS = 9,
  parameter int BLINK_DIV  = 4000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    update_req,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic                    busy,
  output logic                    update_ack,
  output logic [8*NUM_DIGITS-1:0] display_bits
);

  import display_pkg::*;

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  state_t                    state;
  logic [3:0]                digit_idx;
  logic [4*NUM_DIGITS-1:0]   value_q;
  logic [NUM_DIGITS-1:0]     dp_q;
  logic [NUM_DIGITS-1:0]     blank_q;
  logic [NUM_DIGITS-1:0]     blink_q;
  logic [NUM_DIGITS-1:0]     blink_active;
  logic [8*NUM_DIGITS-1:0]   shadow;
  logic [8*NUM_DIGITS-1:0]   committed;
  logic [8*NUM_DIGITS-1:0]   gated;
  logic [CNT_W-1:0]          blink_cnt;
  logic                      blink_phase;
  logic [3:0]                cur_nibble;
  logic [6:0]                cur_segs;

  assign cur_nibble = value_q[{digit_idx, 2'b00} +: 4];

  seg7_font u_font (
    .nibble (cur_nibble),
    .segs   (cur_segs)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      digit_idx    <= '0;
      value_q      <= '0;
      dp_q         <= '0;
      blank_q      <= '0;
      blink_q      <= '0;
      blink_active <= '0;
      shadow       <= '0;
      committed    <= '0;
      busy         <= 1'b0;
      update_ack   <= 1'b0;
    end else begin
      update_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (update_req) begin
            value_q   <= value;
            dp_q      <= dp_mask;
            blank_q   <= blank_mask;
            blink_q   <= blink_mask;
            digit_idx <= '0;
            busy      <= 1'b1;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          shadow[{digit_idx, 3'b000} +: SEG_W] <=
            seg_byte(cur_segs, dp_q[digit_idx], blank_q[digit_idx]);
          if (digit_idx == 4'(NUM_DIGITS - 1)) begin
            digit_idx <= '0;
            state     <= COMMIT;
          end else begin
            digit_idx <= digit_idx + 4'd1;
          end
        end
        COMMIT: begin
          committed    <= shadow;
          blink_active <= blink_q;
          update_ack   <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Blink timebase runs regardless of updates; only reset restarts it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    gated = committed;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (blink_phase && blink_active[i]) gated[8*i +: 8] = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) display_bits <= '0;
    else        display_bits <= gated;
  end

endmodule

// File: tb/tb_display_formatter.sv
// Directed bench for display_formatter with a commit-time scoreboard and a
// cycle-accurate reference of the committed image and blink phase.
module tb_display_formatter;

  localparam int BLINK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        update_req = 1'b0;
  logic [35:0] value = '0;
  logic [8:0]  dp_mask = '0;
  logic [8:0]  blank_mask = '0;
  logic [8:0]  blink_mask = '0;
  logic        busy;
  logic        update_ack;
  logic [71:0] display_bits;

  display_formatter #(.NUM_DIGITS(9), .BLINK_DIV(BLINK_DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .update_req   (update_req),
    .value        (value),
    .dp_mask      (dp_mask),
    .blank_mask   (blank_mask),
    .blink_mask   (blink_mask),
    .busy         (busy),
    .update_ack   (update_ack),
    .display_bits (display_bits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] img;
    logic [8:0]  blink;
    int          commit_cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        popped;
  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  int          m_cnt = 0;
  logic        m_phase = 1'b0;
  logic [71:0] exp_disp = '0;
  logic [71:0] exp_commit = '0;
  logic [8:0]  exp_blink = '0;
  logic        exp_ack = 1'b0;
  logic        exp_busy;

  logic [7:0] font_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  function automatic logic [71:0] encode(input logic [35:0] v, input logic [8:0] dp,
                                         input logic [8:0] blank);
    logic [71:0] r;
    r = '0;
    for (int i = 0; i < 9; i++)
      r[8*i +: 8] = blank[i] ? 8'h00 : (font_tbl[v[4*i +: 4]] | {dp[i], 7'b0});
    return r;
  endfunction

  function automatic logic [71:0] gate(input logic [71:0] img, input logic [8:0] bm,
                                       input logic ph);
    logic [71:0] r;
    r = img;
    for (int i = 0; i < 9; i++)
      if (ph && bm[i]) r[8*i +: 8] = 8'h00;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [71:0] obs,
                             input logic [71:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drives one request cycle from a negedge; accepted requests are scored
  // against the edge that should commit them.
  task automatic applyStimulus(input logic [35:0] v, input logic [8:0] dp,
                               input logic [8:0] bl, input logic [8:0] bk,
                               input bit accept);
    exp_t e;
    value      = v;
    dp_mask    = dp;
    blank_mask = bl;
    blink_mask = bk;
    update_req = 1'b1;
    if (accept) begin
      e.img        = encode(v, dp, bl);
      e.blink      = bk;
      e.commit_cyc = cyc + 11;
      sbq.push_back(e);
    end
    @(negedge clk);
    update_req = 1'b0;
  endtask

  task automatic waitAck(input int budget);
    int waited;
    waited = 0;
    while (update_ack !== 1'b1 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ack_seen", 72'(update_ack), 72'd1);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_cnt      = 0;
      m_phase    = 1'b0;
      exp_disp   = '0;
      exp_commit = '0;
      exp_blink  = '0;
      exp_ack    = 1'b0;
      sbq.delete();
    end else begin
      exp_disp = gate(exp_commit, exp_blink, m_phase);
      exp_ack  = 1'b0;
      if (sbq.size() > 0 && sbq[0].commit_cyc == cyc) begin
        popped     = sbq.pop_front();
        exp_commit = popped.img;
        exp_blink  = popped.blink;
        exp_ack    = 1'b1;
      end
      if (m_cnt == BLINK_DIV - 1) begin
        m_cnt   = 0;
        m_phase = ~m_phase;
      end else begin
        m_cnt++;
      end
    end
  end

  // Every cycle: outputs must match the reference, so a partial image, a
  // stray ack or a wrong busy window is caught wherever it happens.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      exp_busy = (sbq.size() > 0) && (cyc >= sbq[0].commit_cyc - 10);
      checkOutput("display", display_bits, exp_disp);
      checkOutput("busy", 72'(busy), 72'(exp_busy));
      checkOutput("ack", 72'(update_ack), 72'(exp_ack));
    end
  end

  initial begin
    int c0, n_dark, n_lit, n_bad;

    repeat (3) @(negedge clk);
    checkOutput("reset_display", display_bits, 72'h0);
    checkOutput("reset_busy", 72'(busy), 72'd0);
    checkOutput("reset_ack", 72'(update_ack), 72'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(36'h0_1234_5678, 9'h000, 9'h000, 9'h000, 1);
    c0 = cyc;
    waitAck(20);
    checkOutput("basic_latency", 72'(cyc - c0), 72'd10);
    @(negedge clk);
    checkOutput("basic_image", display_bits, 72'h3F_06_5B_4F_66_6D_7D_07_7F);

    applyStimulus(36'hF_FFFF_FFFF, 9'h001, 9'h101, 9'h000, 1);
    waitAck(20);
    @(negedge clk);
    checkOutput("blank_over_dp", display_bits, 72'h00_71_71_71_71_71_71_71_00);
    applyStimulus(36'hF_FFFF_FFFF, 9'h001, 9'h100, 9'h000, 1);
    waitAck(20);
    @(negedge clk);
    checkOutput("dp_lit", display_bits, 72'h00_71_71_71_71_71_71_71_F1);

    applyStimulus(36'h2_2222_2222, 9'h000, 9'h000, 9'h000, 1);
    repeat (3) @(negedge clk);
    applyStimulus(36'h5_5555_5555, 9'h1FF, 9'h000, 9'h000, 0);
    repeat (5) @(negedge clk);
    applyStimulus(36'h5_5555_5555, 9'h1FF, 9'h000, 9'h000, 0);
    checkOutput("ack_a", 72'(update_ack), 72'd1);
    applyStimulus(36'h3_3333_3333, 9'h000, 9'h000, 9'h000, 1);
    checkOutput("image_a", display_bits, 72'h5B_5B_5B_5B_5B_5B_5B_5B_5B);
    c0 = cyc;
    waitAck(20);
    checkOutput("b_latency", 72'(cyc - c0), 72'd10);
    @(negedge clk);
    checkOutput("image_b", display_bits, 72'h4F_4F_4F_4F_4F_4F_4F_4F_4F);

    applyStimulus(36'h0_0000_0088, 9'h000, 9'h000, 9'h003, 1);
    waitAck(20);
    n_dark = 0;
    n_lit  = 0;
    n_bad  = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (display_bits[7:0] == 8'h00) n_dark++;
      if (display_bits[7:0] == 8'h7F) n_lit++;
      if (display_bits[15:8] != display_bits[7:0]) n_bad++;
      if (display_bits[71:16] != 56'h3F_3F_3F_3F_3F_3F_3F) n_bad++;
    end
    checkOutput("blink_dark", 72'(n_dark), 72'd8);
    checkOutput("blink_lit", 72'(n_lit), 72'd8);
    checkOutput("blink_steady", 72'(n_bad), 72'd0);
    applyStimulus(36'h0_0000_0088, 9'h000, 9'h000, 9'h000, 1);
    waitAck(20);
    n_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (display_bits != 72'h3F_3F_3F_3F_3F_3F_3F_7F_7F) n_bad++;
    end
    checkOutput("blink_stopped", 72'(n_bad), 72'd0);

    applyStimulus(36'h7_7777_7777, 9'h000, 9'h000, 9'h000, 1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_busy", 72'(busy), 72'd0);
    checkOutput("midreset_display", display_bits, 72'h0);
    checkOutput("midreset_ack", 72'(update_ack), 72'd0);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    applyStimulus(36'h0_0000_00A1, 9'h000, 9'h000, 9'h000, 1);
    c0 = cyc;
    waitAck(20);
    checkOutput("post_reset_latency", 72'(cyc - c0), 72'd10);
    @(negedge clk);
    checkOutput("post_reset_image", display_bits, 72'h3F_3F_3F_3F_3F_3F_3F_77_06);

    applyStimulus(36'h9_ABCD_EF00, 9'h000, 9'h000, 9'h000, 1);
    value      = 36'h1_1111_1111;
    dp_mask    = 9'h1FF;
    blank_mask = 9'h0F0;
    waitAck(20);
    @(negedge clk);
    checkOutput("capture_hold", display_bits, 72'h6F_77_7C_39_5E_79_71_3F_3F);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/display_formatter.md
Name: display_formatter

Overview:
- Upstream feeder of the front-panel serial display shifter; produces its 72-bit `display_bits` image (9 digits x 8 segment bits).
- Accepts a 9-nibble hex value plus per-digit decimal-point, blank and blink masks on a request/ack handshake.
- Encodes the value one digit per cycle into a shadow image, then commits it atomically so the shifter never sees a partial update.
- Applies a free-running blink to selected digits.

Parameters:
- NUM_DIGITS, 9, digit count; fixed to 9, since the output width is 8*NUM_DIGITS = 72.
- BLINK_DIV, 4000000, blink half-period in clk cycles; must be >= 2.

Ports:
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  synchronous, active-low reset.
- update_req  input  1  single-cycle request; samples the value and mask inputs.
- value  input  36  hex digits; digit i = value[4i+3:4i].
- dp_mask  input  9  bit i lights the decimal point of digit i.
- blank_mask  input  9  bit i forces digit i fully dark, including its DP.
- blink_mask  input  9  bit i makes digit i blink.
- busy  output  1  high while an update is in progress.
- update_ack  output  1  one-cycle pulse when the new image commits.
- display_bits  output  72  segment image; digit i occupies [8i+7:8i], active high.

Behaviour:
- Segment byte layout: bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g, bit7=dp.
- Hex font, 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Reset (rst_n low at a clk edge), all cleared:
  - state = IDLE; busy, update_ack, display_bits = 0.
  - Shadow image, committed image, captured masks and digit index = 0.
  - Blink counter = 0, blink_phase = 0.
- FSM states:
  - IDLE: update_req high at edge N -> capture value and all three masks, digit index = 0, busy = 1, go to CONVERT.
  - CONVERT: edges N+1..N+9 write shadow byte k (k = 0..8).
    - Shadow byte = font(nibble k) | (dp_k << 7).
    - If blank_k is set, the byte is 0x00.
    - Index increments each edge; after k = 8, go to COMMIT.
  - COMMIT: edge N+10 copies shadow to committed and stores the captured blink_mask as the active blink mask. On the same edge, update_ack = 1 for exactly one cycle, busy = 0, return to IDLE.
- Latency: the new image appears on display_bits at edge N+11. display_bits is registered every cycle from the committed image and the blink gating.
- update_req behaviour:
  - Ignored while busy, including during COMMIT.
  - Requests are not queued; the requester waits for update_ack.
  - A request is accepted in the IDLE cycle immediately after update_ack.
- Input capture: value and mask changes after capture do not affect the update in progress.
- Blink:
  - The counter runs continuously from 0 to BLINK_DIV-1; on wrap it returns to 0 and blink_phase toggles.
  - Phase 1: bytes whose active blink bit is set output 0x00. Phase 0: the committed byte is output.
  - The blink counter is independent of the update FSM and is not reset by updates.
- Reset mid-operation: the update is abandoned and all state is cleared as above; no ack is issued.
- Mask bits apply independently per digit. Blank overrides dp. Blink gating applies on top of blank.

Decomposition:
- Package display_pkg:
  - NUM_DIGITS and SEG_W = 8.
  - Segment bit-index constants.
  - FSM state encodings IDLE/CONVERT/COMMIT as 2-bit constants.
  - 16-entry hex font constant.
- Sub-module seg7_font: combinational 4-bit nibble -> 7-bit segments using the package font; instantiated once and shared across digits by the serial conversion.

Test Plan:
- Basic encode: value=36'h0_1234_5678, masks 0, req at edge N -> busy=1 from N to N+9, update_ack=1 only on cycle N+10, display_bits=72'h3F_06_5B_4F_66_6D_7D_07_7F at N+11.
- Masks: value=36'hF_FFFF_FFFF, dp_mask=9'h001, blank_mask=9'h101 -> byte8=00, byte0=00 (blank overrides dp), bytes 1..7 = 71. Repeat with blank_mask=9'h100 -> byte0=F1.
- Busy rejection and atomic commit:
  - Update A in flight; req B at N+4 and at N+10 -> both ignored, display shows A only, exactly one ack.
  - Req B at N+11 -> accepted, ack at N+21.
  - display_bits never shows a mix of A and B bytes.
- Blink: BLINK_DIV=4, blink_mask=9'h003, value=36'h0_0000_0088 -> bytes 0 and 1 alternate 7F and 00 every 4 cycles; other bytes stay 3F. A new update with blink_mask=0 stops blinking from its commit.
- Reset mid-convert: rst_n low at N+5 (sync) -> next edge busy=0, display_bits=0, no ack. Req after reset release completes normally with 11-cycle latency.
- Input change after capture: value switches to 36'h1_1111_1111 at N+1 -> committed image still reflects the value sampled at N.
